// File: rtl/alu_pkg.sv
// Shared definitions for the byte-framed ALU operation sequencer:
// opcode constants, FSM state encoding and default widths.
package alu_pkg;

    localparam int DATA_WIDTH_DEF     = 8;
    localparam int MODE_WIDTH_DEF     = 6;
    localparam int TIMEOUT_CYCLES_DEF = 1000;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    typedef enum logic [2:0] {
        S_GET_A,
        S_GET_B,
        S_GET_OP,
        S_EXEC,
        S_SEND
    } state_t;

    // Top two bits must be clear; the low six must be one of the supported codes.
    function automatic logic opcode_valid(input logic [7:0] op_byte);
        logic ok;
        ok = 1'b0;
        if (op_byte[7:6] == 2'b00) begin
            case (op_byte[5:0])
                OP_ADD, OP_SUB, OP_AND, OP_OR,
                OP_XOR, OP_SRA, OP_SRL, OP_NOR: ok = 1'b1;
                default:                        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bus bundle between the sequencer (slave) and its surroundings: receiver,
// transmitter and the external ALU (master side).
interface alu_op_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MODE_WIDTH = 6
);
    logic [7:0]                   i_rx_data;
    logic                         i_rx_valid;
    logic signed [DATA_WIDTH-1:0] o_alu_a;
    logic signed [DATA_WIDTH-1:0] o_alu_b;
    logic [MODE_WIDTH-1:0]        o_alu_mode;
    logic [DATA_WIDTH-1:0]        i_alu_result;
    logic [7:0]                   o_tx_data;
    logic                         o_tx_valid;
    logic                         i_tx_ready;

    modport slave (
        input  i_rx_data, i_rx_valid, i_alu_result, i_tx_ready,
        output o_alu_a, o_alu_b, o_alu_mode, o_tx_data, o_tx_valid
    );

    modport master (
        output i_rx_data, i_rx_valid, i_alu_result, i_tx_ready,
        input  o_alu_a, o_alu_b, o_alu_mode, o_tx_data, o_tx_valid
    );

endinterface

// File: rtl/byte_timeout_counter.sv
// Inter-byte idle counter; expired stays high once LIMIT idle cycles
// have been counted, until cleared.
module byte_timeout_counter #(
    parameter int LIMIT = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;

    assign expired = (count_q == CW'(LIMIT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Collects an (A, B, opcode) byte frame, drives the external ALU, and hands
// the result byte to the transmitter with a valid/ready handshake.
//
// state    | meaning
// S_GET_A  | idle, waiting for operand A byte
// S_GET_B  | waiting for operand B byte (timeout armed)
// S_GET_OP | waiting for opcode byte (timeout armed)
// S_EXEC   | one cycle for the external ALU result to settle
// S_SEND   | result byte offered until the transmitter accepts it
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int MODE_WIDTH     = MODE_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    alu_op_sequencer_if.slave   bus,
    output logic                o_busy,
    output logic                o_err
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [MODE_WIDTH-1:0] mode_q, mode_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  err_q, err_d;
    logic                  tmo_clear, tmo_enable, tmo_expired;
    logic [7:0]            rx_byte;

    assign rx_byte = bus.i_rx_data;

    byte_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_GET_A;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mode_q     <= mode_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        mode_d     = mode_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;
        tmo_clear  = 1'b0;
        tmo_enable = 1'b0;

        case (state_q)
            S_GET_A: begin
                tmo_clear = 1'b1;
                if (bus.i_rx_valid) begin
                    a_d     = rx_byte;
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                // An expired frame wins over a byte arriving in the same cycle.
                if (tmo_expired) begin
                    err_d     = 1'b1;
                    tmo_clear = 1'b1;
                    state_d   = S_GET_A;
                end else if (bus.i_rx_valid) begin
                    b_d       = rx_byte;
                    tmo_clear = 1'b1;
                    state_d   = S_GET_OP;
                end else begin
                    tmo_enable = 1'b1;
                end
            end
            S_GET_OP: begin
                if (tmo_expired) begin
                    err_d     = 1'b1;
                    tmo_clear = 1'b1;
                    state_d   = S_GET_A;
                end else if (bus.i_rx_valid) begin
                    tmo_clear = 1'b1;
                    if (opcode_valid(rx_byte)) begin
                        mode_d  = rx_byte[MODE_WIDTH-1:0];
                        state_d = S_EXEC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_GET_A;
                    end
                end else begin
                    tmo_enable = 1'b1;
                end
            end
            S_EXEC: begin
                tx_data_d  = bus.i_alu_result;
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (bus.i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_GET_A;
                end
            end
            default: begin
                state_d = S_GET_A;
            end
        endcase
    end

    assign bus.o_alu_a    = a_q;
    assign bus.o_alu_b    = b_q;
    assign bus.o_alu_mode = mode_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_valid = tx_valid_q;
    assign o_busy         = (state_q == S_EXEC) || (state_q == S_SEND);
    assign o_err          = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural external ALU.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    logic busy;
    logic err;
    int   total;
    int   bad;

    alu_op_sequencer_if #(.DATA_WIDTH(8), .MODE_WIDTH(6)) bus ();

    alu_op_sequencer #(
        .DATA_WIDTH     (8),
        .MODE_WIDTH     (6),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_busy  (busy),
        .o_err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: combinational, 8-bit wraparound, shift amount from B[2:0].
    always_comb begin
        case (bus.o_alu_mode)
            6'h20:   bus.i_alu_result = bus.o_alu_a + bus.o_alu_b;
            6'h22:   bus.i_alu_result = bus.o_alu_a - bus.o_alu_b;
            6'h24:   bus.i_alu_result = bus.o_alu_a & bus.o_alu_b;
            6'h25:   bus.i_alu_result = bus.o_alu_a | bus.o_alu_b;
            6'h26:   bus.i_alu_result = bus.o_alu_a ^ bus.o_alu_b;
            6'h03:   bus.i_alu_result = $signed(bus.o_alu_a) >>> bus.o_alu_b[2:0];
            6'h02:   bus.i_alu_result = bus.o_alu_a >> bus.o_alu_b[2:0];
            6'h27:   bus.i_alu_result = ~(bus.o_alu_a | bus.o_alu_b);
            default: bus.i_alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        tick();
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a"},      32'(bus.o_alu_a),    32'h0);
        chk({tag, "_b"},      32'(bus.o_alu_b),    32'h0);
        chk({tag, "_mode"},   32'(bus.o_alu_mode), 32'h0);
        chk({tag, "_txdata"}, 32'(bus.o_tx_data),  32'h0);
        chk({tag, "_txvalid"},32'(bus.o_tx_valid), 32'h0);
        chk({tag, "_busy"},   32'(busy),           32'h0);
        chk({tag, "_err"},    32'(err),            32'h0);
        chk({tag, "_state"},  32'(dut.state_q),    32'(S_GET_A));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n          = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_tx_ready = 1'b0;

        // Reset values
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 5 + 3 with an always-ready transmitter
        bus.i_tx_ready = 1'b1;
        send(8'h05);
        send(8'h03);
        send(8'h20);
        chk("add_mode",         32'(bus.o_alu_mode), 32'h20);
        chk("add_a",            32'(bus.o_alu_a),    32'h05);
        chk("add_b",            32'(bus.o_alu_b),    32'h03);
        chk("add_busy_exec",    32'(busy),           32'h1);
        chk("add_valid_early",  32'(bus.o_tx_valid), 32'h0);
        tick();
        chk("add_valid",        32'(bus.o_tx_valid), 32'h1);
        chk("add_data",         32'(bus.o_tx_data),  32'h08);
        tick();
        chk("add_valid_drop",   32'(bus.o_tx_valid), 32'h0);
        chk("add_busy_done",    32'(busy),           32'h0);

        // 3 - 5 with the transmitter stalled; a byte sent meanwhile is dropped
        bus.i_tx_ready = 1'b0;
        send(8'h03);
        send(8'h05);
        send(8'h22);
        tick();
        chk("sub_valid",        32'(bus.o_tx_valid), 32'h1);
        chk("sub_data",         32'(bus.o_tx_data),  32'h0FE);
        chk("sub_busy",         32'(busy),           32'h1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) send(8'h77);
            else        tick();
            chk("sub_hold_valid", 32'(bus.o_tx_valid), 32'h1);
            chk("sub_hold_data",  32'(bus.o_tx_data),  32'h0FE);
        end
        chk("sub_drop_a",       32'(bus.o_alu_a),    32'h03);
        chk("sub_drop_b",       32'(bus.o_alu_b),    32'h05);
        bus.i_tx_ready = 1'b1;
        tick();
        chk("sub_valid_drop",   32'(bus.o_tx_valid), 32'h0);
        chk("sub_busy_done",    32'(busy),           32'h0);

        // Arithmetic vs logical right shift of 0x80 by 2
        send(8'h80);
        send(8'h02);
        send(8'h03);
        tick();
        chk("sra_data",         32'(bus.o_tx_data),  32'h0E0);
        tick();
        send(8'h80);
        send(8'h02);
        send(8'h02);
        tick();
        chk("srl_data",         32'(bus.o_tx_data),  32'h20);
        chk("srl_valid",        32'(bus.o_tx_valid), 32'h1);
        tick();

        // Invalid opcodes: low bits not in the set, then top bits set
        send(8'h01);
        send(8'h02);
        send(8'h21);
        chk("bad21_err",        32'(err),            32'h1);
        chk("bad21_mode",       32'(bus.o_alu_mode), 32'h02);
        chk("bad21_busy",       32'(busy),           32'h0);
        tick();
        chk("bad21_err_pulse",  32'(err),            32'h0);
        chk("bad21_no_tx",      32'(bus.o_tx_valid), 32'h0);
        send(8'h01);
        send(8'h02);
        send(8'hE0);
        chk("badE0_err",        32'(err),            32'h1);
        chk("badE0_mode",       32'(bus.o_alu_mode), 32'h02);
        tick();
        chk("badE0_err_pulse",  32'(err),            32'h0);
        chk("badE0_no_tx",      32'(bus.o_tx_valid), 32'h0);
        send(8'hF0);
        send(8'h0F);
        send(8'h27);
        tick();
        chk("nor_data",         32'(bus.o_tx_data),  32'h00);
        chk("nor_valid",        32'(bus.o_tx_valid), 32'h1);
        tick();

        // Timeout after operand A: 1000 idle cycles counted, expiry acts on the next edge
        send(8'h10);
        repeat (1000) tick();
        chk("tmo_err_before",   32'(err),            32'h0);
        chk("tmo_state_before", 32'(dut.state_q),    32'(S_GET_B));
        tick();
        chk("tmo_err",          32'(err),            32'h1);
        chk("tmo_state",        32'(dut.state_q),    32'(S_GET_A));
        tick();
        chk("tmo_err_pulse",    32'(err),            32'h0);
        send(8'h0C);
        send(8'h0A);
        send(8'h24);
        tick();
        chk("and_data",         32'(bus.o_tx_data),  32'h08);
        chk("and_valid",        32'(bus.o_tx_valid), 32'h1);
        tick();

        // Reset while a result is waiting in S_SEND
        bus.i_tx_ready = 1'b0;
        send(8'h11);
        send(8'h22);
        send(8'h20);
        tick();
        chk("rst_pre_valid",    32'(bus.o_tx_valid), 32'h1);
        chk("rst_pre_data",     32'(bus.o_tx_data),  32'h33);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        bus.i_tx_ready = 1'b1;
        tick();
        tick();
        chk("post_rst_no_tx",   32'(bus.o_tx_valid), 32'h0);
        send(8'h04);
        chk("post_rst_a",       32'(bus.o_alu_a),    32'h04);
        chk("post_rst_state",   32'(dut.state_q),    32'(S_GET_B));
        send(8'h05);
        send(8'h20);
        tick();
        chk("post_rst_data",    32'(bus.o_tx_data),  32'h09);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
